// File: rtl/seq_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module   : seq_slice_adder
//  Purpose  : Serial add/subtract unit. Processes one 4-bit slice per clock,
//             least significant slice first, using a 4-bit lookahead carry
//             per slice and a registered carry between slices.
//  Revision : 1.0  initial release
// ============================================================================
module seq_slice_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;      // operands, shifted right one slice per cycle
    logic [WIDTH-1:0] sum_q;         // partial sums, shifted in from the top
    logic             carry_q;       // carry into the current slice
    logic [KW-1:0]    k_q;           // current slice index
    logic             busy_q, done_q, cout_q, ovf_q, zero_q;
    logic [WIDTH-1:0] result_q;

    logic [3:0]       w_d, w_f, w_p, w_sum;
    logic [WIDTH-1:0] w_final;

    // Slice lookahead carries and sum for the current low slice of the operands
    always_comb begin
        w_d = a_q[3:0] & b_q[3:0];
        w_f = a_q[3:0] | b_q[3:0];
        w_p[0] = w_d[0] | (w_f[0] & carry_q);
        w_p[1] = w_d[1] | (w_f[1] & w_d[0]) | (w_f[1] & w_f[0] & carry_q);
        w_p[2] = w_d[2] | (w_f[2] & w_d[1]) | (w_f[2] & w_f[1] & w_d[0])
               | (w_f[2] & w_f[1] & w_f[0] & carry_q);
        w_p[3] = w_d[3] | (w_f[3] & w_d[2]) | (w_f[3] & w_f[2] & w_d[1])
               | (w_f[3] & w_f[2] & w_f[1] & w_d[0])
               | (w_f[3] & w_f[2] & w_f[1] & w_f[0] & carry_q);
        w_sum  = a_q[3:0] ^ b_q[3:0] ^ {w_p[2:0], carry_q};
        // On the last slice the shift buffer plus the new slice is the full result
        w_final = {w_sum, sum_q[WIDTH-1:4]};
    end

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    sum_q   <= w_final;
                    carry_q <= w_p[3];
                    k_q     <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        // Carry into the MSB is w_p[2] of the top slice
                        result_q <= w_final;
                        cout_q   <= w_p[3];
                        ovf_q    <= w_p[3] ^ w_p[2];
                        zero_q   <= (w_final == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_slice_adder
//  Purpose  : Self-checking bench for seq_slice_adder (WIDTH=16, N=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_slice_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    seq_slice_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
        .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain modulo arithmetic on the whole word
    task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic co, output logic ov,
                         output logic z);
        logic [W-1:0] yy;
        logic [W:0]   full;
        logic [W-1:0] low;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
        low  = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + W'(s);
        r    = full[W-1:0];
        co   = full[W];
        ov   = full[W] ^ low[W-1];
        z    = (full[W-1:0] == '0);
    endtask

    // Start one op from idle and wait (bounded) for its done pulse
    task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic co, output logic ov,
                         output logic z, output int lat);
        @(negedge clk);
        start = 1'b1; sub = s; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; sub = ~s; a = W'($urandom); b = W'($urandom);
        lat = 0; r = '0; co = 1'b0; ov = 1'b0; z = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = i; r = result; co = cout; ov = ovf; z = zero;
            end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    logic [W-1:0] er, gr;
    logic         eco, eov, ez, gco, gov, gz;
    int           lat, ndone;

    initial begin
        tbl[0] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].s, tbl[i].x, tbl[i].y, gr, gco, gov, gz, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd4);
            chk($sformatf("tbl%0d_result", i), 32'(gr), 32'(tbl[i].r));
            chk($sformatf("tbl%0d_flags", i), {29'd0, gco, gov, gz},
                {29'd0, tbl[i].co, tbl[i].ov, tbl[i].z});
        end

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic         s;
            logic [W-1:0] x, y;
            s = 1'($urandom);
            x = W'($urandom);
            y = (i % 8 == 0) ? x : W'($urandom);
            model(s, x, y, er, eco, eov, ez);
            do_op(s, x, y, gr, gco, gov, gz, lat);
            chk($sformatf("rnd%0d_result", i), 32'(gr), 32'(er));
            chk($sformatf("rnd%0d_flags", i), {29'd0, gco, gov, gz}, {29'd0, eco, eov, ez});
        end

        // Start re-pulsed during RUN with other operands is ignored
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h1111;
        @(posedge clk);
        #1;
        sub = 1'b1; a = 16'hAAAA; b = 16'h5555;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; gr = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++; gr = result;
            end
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_result", 32'(gr), 32'h2345);

        // Start held through the DONE cycle: back-to-back second op
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h0100; b = 16'h0023;
        @(posedge clk);
        #1;
        sub = 1'b1; a = 16'h0050; b = 16'h0060;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_result1", 32'(result), 32'h0123);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy2", {30'd0, busy, done}, 32'd2);
        chk("b2b_hold", 32'(result), 32'h0123);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b2b_done_c%0d", i), 32'(done), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("b2b_result2", 32'(result), 32'hFFF0);
        chk("b2b_flags2", {29'd0, cout, ovf, zero}, 32'd0);

        // Reset during RUN aborts the op and clears outputs at once
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h4321; b = 16'h1000;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("mrst_result", 32'(result), 32'd0);
        chk("mrst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mrst_no_done", 32'(ndone), 32'd0);
        do_op(1'b0, 16'h1111, 16'h2222, gr, gco, gov, gz, lat);
        chk("mrst_next_lat", 32'(lat), 32'd4);
        chk("mrst_next_result", 32'(gr), 32'h3333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
